id_hazard_scoreboard: RTL and testbench

Register scoreboard and stall sequencer for the instruction-decode stage. It tracks the in-flight writers of every architectural register between ID issue and WB retire. It stalls ID when a source operand or destination slot is unavailable. A drain FSM quiesces the pipeline on request, for example before a halt or a debug read of the register file.

---
 rtl/id_hazard_scoreboard_pkg.sv | 17 +
 rtl/id_scoreboard_counter.sv | 34 +++
 rtl/id_hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage register scoreboard: drain FSM
// encoding, the hardwired-zero register index and default widths.
package id_hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } drainState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEFAULT_NUM_REGS    = 32;
    localparam int DEFAULT_CNT_W       = 2;
    localparam int DEFAULT_STALL_CNT_W = 16;

endpackage

// File: rtl/id_scoreboard_counter.sv
// One per-register in-flight writer counter. An issue and a retire in
// the same cycle cancel; a retire at zero holds the count and pulses
// underflow.
module id_scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic inc,
    input  logic dec,
    output logic atZero,
    output logic atMax,
    output logic underflow
);

    logic [CNT_W-1:0] count;

    assign atZero    = (count == '0);
    assign atMax     = (count == '1);
    assign underflow = dec & atZero;

    // Count up on issue, down on retire, unchanged when both or neither.
    // NOTE: state registers use non-blocking assignments so every counter samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (inc & ~dec & ~atMax) begin
            count <= count + 1'b1;
        end else if (dec & ~inc & ~atZero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage scoreboard: tracks in-flight writers per register, stalls ID
// on RAW or destination-slot hazards, and sequences a drain-and-hold
// request down to an empty pipeline.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int STALL_CNT_W = DEFAULT_STALL_CNT_W
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   IssueValid,
    input  logic [4:0]             ReadRegister1,
    input  logic [4:0]             ReadRegister2,
    input  logic                   UsesRs,
    input  logic                   UsesRt,
    input  logic                   DestValid,
    input  logic [4:0]             DestRegister,
    input  logic                   Flush,
    input  logic                   RegWrite_WB,
    input  logic [4:0]             WriteRegister_WB,
    input  logic                   DrainReq,
    output logic                   Stall,
    output logic                   IssueAccept,
    output logic                   Drained,
    output logic [STALL_CNT_W-1:0] StallCount,
    output logic                   Error
);

    drainState_t state;
    logic        drainedQ;

    logic [NUM_REGS-1:0] regAtZero;
    logic [NUM_REGS-1:0] regAtMax;
    logic [NUM_REGS-1:0] regUnderflow;

    logic rsHazard;
    logic rtHazard;
    logic destHazard;
    logic blockIssue;
    logic issueLive;
    logic allZero;

    // Register 0 is never tracked: always empty, never full, never underflows.
    assign regAtZero[0]    = 1'b1;
    assign regAtMax[0]     = 1'b0;
    assign regUnderflow[0] = 1'b0;

    // NOTE: counters are reset individually because the hazard logic reads every one of them.
    for (genvar r = 1; r < NUM_REGS; r++) begin : genCounter
        logic regInc;
        logic regDec;

        assign regInc = IssueAccept & DestValid & (DestRegister == 5'(r));
        assign regDec = RegWrite_WB & (WriteRegister_WB == 5'(r));

        id_scoreboard_counter #(
            .CNT_W (CNT_W)
        ) uCounter (
            .Clk       (Clk),
            .Rst       (Rst),
            .inc       (regInc),
            .dec       (regDec),
            .atZero    (regAtZero[r]),
            .atMax     (regAtMax[r]),
            .underflow (regUnderflow[r])
        );
    end

    // Hazards use registered counts only; a same-cycle retire does not bypass.
    assign rsHazard   = UsesRs & (ReadRegister1 != REG_ZERO) & ~regAtZero[ReadRegister1];
    assign rtHazard   = UsesRt & (ReadRegister2 != REG_ZERO) & ~regAtZero[ReadRegister2];
    assign destHazard = DestValid & (DestRegister != REG_ZERO) & regAtMax[DestRegister];
    assign blockIssue = rsHazard | rtHazard | destHazard | (state != RUN);

    // Flush wins over stall; nothing moves while reset is held.
    assign issueLive   = IssueValid & ~Flush & ~Rst;
    assign Stall       = issueLive & blockIssue;
    assign IssueAccept = issueLive & ~blockIssue;
    assign Drained     = drainedQ & ~Rst;
    assign allZero     = &regAtZero;

    // Drain sequencer with registered Drained flag.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= RUN;
            drainedQ <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (DrainReq) state <= DRAIN;
                end
                DRAIN: begin
                    if (!DrainReq) begin
                        state <= RUN;
                    end else if (allZero) begin
                        state    <= HALTED;
                        drainedQ <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!DrainReq) begin
                        state    <= RUN;
                        drainedQ <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    drainedQ <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != '1)) begin
            StallCount <= StallCount + 1'b1;
        end
    end

    // Sticky flag for a retire that found no in-flight writer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Error <= 1'b0;
        end else if (|regUnderflow) begin
            Error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_id_hazard_scoreboard;

    localparam int MAXC    = 3;
    localparam int SC_MAX  = 65535;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IssueValid;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        UsesRs;
    logic        UsesRt;
    logic        DestValid;
    logic [4:0]  DestRegister;
    logic        Flush;
    logic        RegWrite_WB;
    logic [4:0]  WriteRegister_WB;
    logic        DrainReq;
    logic        Stall;
    logic        IssueAccept;
    logic        Drained;
    logic [15:0] StallCount;
    logic        Error;

    int nVec = 0;
    int nMis = 0;

    // Behavioural model state
    int mCnt [32];
    int mState;
    int mStallCnt;
    bit mErr;
    bit mValid = 1'b0;

    id_hazard_scoreboard dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .IssueValid       (IssueValid),
        .ReadRegister1    (ReadRegister1),
        .ReadRegister2    (ReadRegister2),
        .UsesRs           (UsesRs),
        .UsesRt           (UsesRt),
        .DestValid        (DestValid),
        .DestRegister     (DestRegister),
        .Flush            (Flush),
        .RegWrite_WB      (RegWrite_WB),
        .WriteRegister_WB (WriteRegister_WB),
        .DrainReq         (DrainReq),
        .Stall            (Stall),
        .IssueAccept      (IssueAccept),
        .Drained          (Drained),
        .StallCount       (StallCount),
        .Error            (Error)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelHazard();
        bit h;
        h = 1'b0;
        if (UsesRs && ReadRegister1 != 0 && mCnt[ReadRegister1] != 0) h = 1'b1;
        if (UsesRt && ReadRegister2 != 0 && mCnt[ReadRegister2] != 0) h = 1'b1;
        if (DestValid && DestRegister != 0 && mCnt[DestRegister] == MAXC) h = 1'b1;
        return h;
    endfunction

    function automatic bit expStall();
        return !Rst && IssueValid && !Flush && (modelHazard() || mState != M_RUN);
    endfunction

    function automatic bit expAccept();
        return !Rst && IssueValid && !Flush && !(modelHazard() || mState != M_RUN);
    endfunction

    function automatic bit expDrained();
        return !Rst && mState == M_HALT;
    endfunction

    // Model advance at each rising edge from the pre-edge model and inputs.
    always @(posedge Clk) begin
        bit acc, st, empty, incOn, decOn;
        int d, w;
        if (Rst) begin
            for (int i = 0; i < 32; i++) mCnt[i] = 0;
            mState = M_RUN;
            mStallCnt = 0;
            mErr = 1'b0;
            mValid = 1'b1;
        end else if (mValid) begin
            acc = expAccept();
            st = expStall();
            empty = 1'b1;
            for (int i = 0; i < 32; i++) if (mCnt[i] != 0) empty = 1'b0;
            d = int'(DestRegister);
            w = int'(WriteRegister_WB);
            incOn = acc && DestValid && d != 0;
            decOn = RegWrite_WB && w != 0;
            if (decOn && mCnt[w] == 0) mErr = 1'b1;
            if (!(incOn && decOn && d == w)) begin
                if (incOn) mCnt[d] = mCnt[d] + 1;
                if (decOn && mCnt[w] > 0) mCnt[w] = mCnt[w] - 1;
            end
            if (st && mStallCnt < SC_MAX) mStallCnt = mStallCnt + 1;
            case (mState)
                M_RUN:   if (DrainReq) mState = M_DRAIN;
                M_DRAIN: if (!DrainReq) mState = M_RUN; else if (empty) mState = M_HALT;
                default: if (!DrainReq) mState = M_RUN;
            endcase
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge Clk) begin
        check("model_stall", 32'(Stall), 32'(expStall()));
        check("model_accept", 32'(IssueAccept), 32'(expAccept()));
        check("model_drained", 32'(Drained), 32'(expDrained()));
        if (mValid) begin
            check("model_stallcount", 32'(StallCount), 32'(mStallCnt));
            check("model_error", 32'(Error), 32'(mErr));
        end
    end

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearIn();
        IssueValid = 0; ReadRegister1 = 0; ReadRegister2 = 0; UsesRs = 0; UsesRt = 0;
        DestValid = 0; DestRegister = 0; Flush = 0; RegWrite_WB = 0; WriteRegister_WB = 0;
    endtask

    task automatic issueWrite(input logic [4:0] dest);
        clearIn();
        IssueValid = 1; DestValid = 1; DestRegister = dest;
    endtask

    task automatic issueRead(input logic [4:0] rs);
        clearIn();
        IssueValid = 1; UsesRs = 1; ReadRegister1 = rs;
    endtask

    task automatic retire(input logic [4:0] r);
        clearIn();
        RegWrite_WB = 1; WriteRegister_WB = r;
    endtask

    task automatic chk2(input string name, input logic expS, input logic expA);
        @(negedge Clk);
        check({name, "_stall"}, 32'(Stall), 32'(expS));
        check({name, "_accept"}, 32'(IssueAccept), 32'(expA));
    endtask

    initial begin
        logic [4:0] w;
        Rst = 1; DrainReq = 0;
        clearIn();
        IssueValid = 1; UsesRs = 1; ReadRegister1 = 5'd1;
        @(negedge Clk);
        check("rst_stall", 32'(Stall), 0);
        check("rst_accept", 32'(IssueAccept), 0);
        check("rst_drained", 32'(Drained), 0);
        check("rst_stallcount", 32'(StallCount), 0);
        check("rst_error", 32'(Error), 0);
        nextCycle();
        nextCycle();
        Rst = 0;

        // Load-use on register 8
        issueWrite(5'd8);          chk2("lu_issue", 0, 1);
        nextCycle(); issueRead(5'd8); chk2("lu_use", 1, 0);
        check("lu_sc0", 32'(StallCount), 0);
        nextCycle(); issueRead(5'd8); RegWrite_WB = 1; WriteRegister_WB = 5'd8;
        chk2("lu_nobypass", 1, 0);
        check("lu_sc1", 32'(StallCount), 1);
        nextCycle(); issueRead(5'd8); chk2("lu_release", 0, 1);
        check("lu_sc2", 32'(StallCount), 2);

        // Register 0 never tracked
        for (int i = 0; i < 3; i++) begin
            nextCycle(); issueWrite(5'd0); chk2("r0_write", 0, 1);
        end
        nextCycle(); clearIn(); IssueValid = 1; UsesRs = 1; UsesRt = 1; DestValid = 1;
        chk2("r0_read", 0, 1);

        // Saturation on register 5
        for (int i = 0; i < 3; i++) begin
            nextCycle(); issueWrite(5'd5); chk2("sat_fill", 0, 1);
        end
        nextCycle(); issueWrite(5'd5); chk2("sat_full", 1, 0);
        nextCycle(); issueWrite(5'd5); RegWrite_WB = 1; WriteRegister_WB = 5'd5;
        chk2("sat_retire", 1, 0);
        nextCycle(); issueWrite(5'd5); chk2("sat_accept", 0, 1);
        for (int i = 0; i < 3; i++) begin
            nextCycle(); retire(5'd5);
        end
        nextCycle(); issueRead(5'd5); chk2("sat_empty", 0, 1);

        // Simultaneous issue and retire on register 9, then flush
        nextCycle(); issueWrite(5'd9); chk2("sim_first", 0, 1);
        nextCycle(); issueWrite(5'd9); RegWrite_WB = 1; WriteRegister_WB = 5'd9;
        chk2("sim_both", 0, 1);
        nextCycle(); issueRead(5'd9); chk2("sim_still", 1, 0);
        nextCycle(); issueRead(5'd9); Flush = 1; DestValid = 1; DestRegister = 5'd9;
        chk2("flush", 0, 0);
        nextCycle(); retire(5'd9);
        nextCycle(); issueRead(5'd9); chk2("sim_clear", 0, 1);

        // Drain with pending writers
        nextCycle(); issueWrite(5'd3); chk2("dr_w3", 0, 1);
        nextCycle(); issueWrite(5'd4); chk2("dr_w4", 0, 1);
        nextCycle(); issueWrite(5'd6); DrainReq = 1; chk2("dr_edge", 0, 1);
        nextCycle(); retire(5'd3); IssueValid = 1; chk2("dr_hold1", 1, 0);
        nextCycle(); retire(5'd4); IssueValid = 1; chk2("dr_hold2", 1, 0);
        nextCycle(); retire(5'd6); IssueValid = 1; chk2("dr_hold3", 1, 0);
        check("dr_notyet", 32'(Drained), 0);
        nextCycle(); clearIn(); IssueValid = 1; chk2("dr_hold4", 1, 0);
        check("dr_observe", 32'(Drained), 0);
        nextCycle(); clearIn(); IssueValid = 1; DrainReq = 0; chk2("dr_halted", 1, 0);
        check("dr_drained", 32'(Drained), 1);
        nextCycle(); clearIn(); IssueValid = 1; chk2("dr_resume", 0, 1);
        check("dr_undrained", 32'(Drained), 0);

        // Underflow, then reset in the middle of a drain
        nextCycle(); retire(5'd12);
        nextCycle(); clearIn(); @(negedge Clk);
        check("uf_error", 32'(Error), 1);
        nextCycle(); issueWrite(5'd7);
        nextCycle(); clearIn(); DrainReq = 1;
        nextCycle(); clearIn(); IssueValid = 1; chk2("rd_draining", 1, 0);
        nextCycle(); Rst = 1; DrainReq = 0; clearIn(); IssueValid = 1; chk2("rd_inrst", 0, 0);
        nextCycle(); Rst = 0; issueRead(5'd7); chk2("rd_after", 0, 1);
        check("rd_error", 32'(Error), 0);
        check("rd_sc", 32'(StallCount), 0);
        check("rd_drained", 32'(Drained), 0);

        // Randomized traffic on a small register window
        for (int cyc = 0; cyc < 4000; cyc++) begin
            nextCycle();
            Rst = ($urandom_range(0, 299) == 0);
            IssueValid = ($urandom_range(0, 3) != 0);
            ReadRegister1 = 5'($urandom_range(0, 7));
            ReadRegister2 = 5'($urandom_range(0, 7));
            UsesRs = 1'($urandom_range(0, 1));
            UsesRt = 1'($urandom_range(0, 1));
            DestValid = ($urandom_range(0, 3) != 0);
            DestRegister = 5'($urandom_range(0, 7));
            Flush = ($urandom_range(0, 7) == 0);
            w = 5'($urandom_range(1, 7));
            if (mCnt[w] > 0) RegWrite_WB = 1'($urandom_range(0, 1));
            else RegWrite_WB = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) begin
                RegWrite_WB = 1; w = 5'd0;
            end
            WriteRegister_WB = w;
            if ($urandom_range(0, 39) == 0) DrainReq = ~DrainReq;
        end

        nextCycle(); clearIn(); Rst = 0; DrainReq = 0;
        nextCycle();
        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
